pn_sym_sched: RTL and testbench
===============================

// Module: pn_sym_sched
// PURPOSE
//  Sequencer between the PN15 bit source and the digital modulators (ASK/FSK/PSK/QPSK).
//  Paces the PN source at a programmable bit rate and packs PN bits into 1..SYM_W-bit symbols.
//  Prepends a fixed-length alternating preamble to each frame.
//  Delivers symbols over a valid/ready handshake and stalls the PN source under backpressure.
// PARAMETERS
//  DIV_W     16    width of bit-rate divider input div
//  SYM_W     3     max bits per symbol; width of sym_data
//  PRE_LEN   16    preamble length in symbols (>=1)
//  FRAME_LEN 1024  payload length in symbols per frame (>=1)
// PORTS
//  clk        in   1      system clock; all logic on posedge
//  rst        in   1      asynchronous, active-low reset
//  start      in   1      1-cycle pulse; starts a frame when IDLE
//  stop       in   1      level/pulse; aborts the frame and returns to IDLE
//  div        in   DIV_W  bit period = div+1 clk cycles; latched at start
//  mode       in   2      bits per symbol (0 treated as 1, max SYM_W); latched at start
//  pn_bit     in   1      current PN output bit
//  pn_en      out  1      1-cycle advance strobe to the PN generator
//  sym_data   out  SYM_W  symbol, right-justified, first bit in MSB of used field
//  sym_valid  out  1      sym_data valid; held until accepted
//  sym_ready  in   1      modulator accepts symbol when valid&ready
//  busy       out  1      high in PRE or PAY state
//  frame_done out  1      1-cycle pulse on acceptance of last payload symbol
// BEHAVIOUR
//  Reset: state=IDLE; pn_en, sym_valid, busy, frame_done=0; sym_data=0; counters=0.
//  FSM: IDLE -start-> PRE -PRE_LEN symbols accepted-> PAY -FRAME_LEN accepted-> IDLE.
//   stop has priority over everything: the next state is IDLE. sym_valid, pn_en and partial symbol are cleared.
//   start is ignored outside IDLE. start and stop in the same cycle: stay IDLE.
//  Divider: counts 0..div_l in PRE/PAY; bit tick when count==div_l; div=0 -> tick every clk.
//   Stall: while sym_valid&&!sym_ready and the accumulator is full, the counter holds at div_l and no tick occurs.
//  PRE: every mode_l ticks forms one symbol; values alternate all-zeros / all-ones (mask to mode_l bits).
//   The first preamble symbol is zeros. pn_en stays 0 in PRE.
//  PAY: each tick asserts pn_en for exactly 1 cycle and samples pn_bit in that same cycle.
//   Sampled bits shift into the accumulator MSB-first. After mode_l bits, sym_data is loaded.
//   sym_valid is set on the following edge, i.e. 1 clk latency from the last bit tick.
//  Handshake: symbol transfers on the edge where sym_valid&&sym_ready. sym_valid drops unless the next symbol is loading in the same cycle.
//   A new symbol may complete while the previous one waits only if the accumulator has not yet filled.
//   No symbol is ever dropped or duplicated.
//  Counters: sym_cnt counts accepted symbols per phase and clears on the PRE->PAY and PAY->IDLE transitions.
//   frame_done pulses in the cycle after the last PAY acceptance; busy falls in that same cycle.
//  Width: mode_l = (mode==0)?1:min(mode,SYM_W). Unused upper sym_data bits = 0.
//  Mid-operation reset: asynchronous return to reset values; no partial symbol is emitted afterwards.
// CONFIGURATION
//  PN_SCHED_LOOP_EN defined: at payload end, FSM goes PAY->PRE (continuous framing) instead of IDLE.
//   frame_done still pulses every frame; busy stays 1. The only exit is stop or reset.
//  PN_SCHED_LOOP_EN undefined: single-shot; PAY->IDLE after FRAME_LEN symbols.
// TESTING
//  T1 reset: rst=0 mid-PAY with sym_valid=1 -> all outputs 0 within the same cycle; IDLE after release.
//   No stray pn_en.
//  T2 BPSK: mode=1, div=3, sym_ready=1, PRE_LEN=16 -> 16 preamble symbols 0,1,0,1...
//   Then pn_en exactly every 4 clk. sym_data matches the PN15 sequence (seed 0111_0111_0111_011) bit-for-bit.
//  T3 QPSK: mode=2, div=0, PN bits 1,0,1,1 -> payload symbols 2'b10, 2'b11. Preamble values are 00, 11.
//  T4 backpressure: sym_ready=0 for 50 clk mid-PAY -> pn_en stops after the accumulator fills.
//   sym_data stays stable; no lost symbols after release (compare against the reference model).
//  T5 stop/start: stop pulse at payload symbol 100 -> IDLE next cycle, busy=0, no frame_done.
//   start+stop in the same cycle -> stays IDLE.
//  T6 frame end: FRAME_LEN=8 -> frame_done 1-cycle pulse after the 8th acceptance.
//   With PN_SCHED_LOOP_EN, a second preamble follows immediately.

Source files
------------

// File: rtl/pn_sym_sched.sv
// -----------------------------------------------------------------------------
// pn_sym_sched
//   Sequencer between the PN15 bit source and the digital modulators.
//   It paces the PN source at a programmable bit rate and packs PN bits into
//   1..SYM_W-bit symbols. Each frame starts with an alternating
//   0 / all-ones preamble. Symbols go out on a valid/ready handshake, and the
//   PN source is stalled under backpressure.
//
//   Optional build macro: PN_SCHED_LOOP_EN
//     defined   : continuous framing (PAY -> PRE at frame end; exit only by stop/reset)
//     undefined : single shot (PAY -> IDLE at frame end)
//
// Ports
//   clk        system clock, posedge
//   rst        asynchronous active-low reset
//   start      1-cycle pulse, starts a frame from IDLE
//   stop       aborts the frame, returns to IDLE (highest priority)
//   div        bit period = div+1 clocks, latched at start
//   mode       bits per symbol (0 -> 1, clipped to SYM_W), latched at start
//   pn_bit     current PN bit, sampled while pn_en is high
//   pn_en      1-cycle advance strobe to the PN generator
//   sym_data   right-justified symbol, first bit in MSB of the used field
//   sym_valid  symbol valid, held until accepted
//   sym_ready  modulator accepts on sym_valid & sym_ready
//   busy       high in PRE or PAY
//   frame_done 1-cycle pulse after the last payload symbol is accepted
// -----------------------------------------------------------------------------
module pn_sym_sched #(
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned SYM_W     = 3,
  parameter int unsigned PRE_LEN   = 16,
  parameter int unsigned FRAME_LEN = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] div,
  input  logic [1:0]       mode,
  input  logic             pn_bit,
  output logic             pn_en,
  output logic [SYM_W-1:0] sym_data,
  output logic             sym_valid,
  input  logic             sym_ready,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned MW     = $clog2(SYM_W + 1);
  localparam int unsigned MAXLEN = (PRE_LEN > FRAME_LEN) ? PRE_LEN : FRAME_LEN;
  localparam int unsigned CW     = $clog2(MAXLEN + 1);
  localparam logic [CW-1:0] PRE_N   = CW'(PRE_LEN);
  localparam logic [CW-1:0] FRAME_N = CW'(FRAME_LEN);

  typedef enum logic [1:0] {IDLE, PRE, PAY} state_t;

  state_t           state, state_nx;
  logic [DIV_W-1:0] div_l, cnt;
  logic [MW-1:0]    mode_l, mode_eff, bit_cnt, bits_after;
  logic [SYM_W-1:0] acc;
  logic [CW-1:0]    gen_cnt, sym_cnt, phase_len;
  logic             pre_bit;
  logic             active, acc_full, accept, stall, gen_done;
  logic             tick, load, filled, last_acc, in_bit;

  assign mode_eff = (mode == 2'd0)          ? MW'(1) :
                    (32'(mode) > SYM_W)     ? MW'(SYM_W) : MW'(mode);

  assign active    = (state != IDLE);
  assign phase_len = (state == PAY) ? FRAME_N : PRE_N;
  assign acc_full  = (bit_cnt == mode_l);
  assign accept    = sym_valid && sym_ready;
  assign stall     = sym_valid && !sym_ready && acc_full;
  // Once every symbol of the phase has been assembled, the divider parks and
  // no further bits are drawn until the phase changes.
  assign gen_done  = (gen_cnt == phase_len);
  assign tick      = active && !stop && !gen_done && !stall && (cnt == div_l);
  // A full accumulator moves to the output register whenever that register
  // is empty or being emptied this cycle; a tick in the same cycle starts
  // the next symbol in the freshly cleared accumulator.
  assign load       = active && !stop && acc_full && (!sym_valid || sym_ready);
  assign bits_after = (load ? '0 : bit_cnt) + MW'(1);
  assign filled     = tick && (bits_after == mode_l);
  assign last_acc   = accept && (sym_cnt == phase_len - CW'(1));
  assign in_bit     = (state == PAY) ? pn_bit : pre_bit;

  always_comb begin
    state_nx = state;
    pn_en    = 1'b0;
    busy     = active;
    case (state)
      IDLE: if (start && !stop) state_nx = PRE;
      PRE: begin
        if (stop)          state_nx = IDLE;
        else if (last_acc) state_nx = PAY;
      end
      PAY: begin
        pn_en = tick;
        if (stop)          state_nx = IDLE;
`ifdef PN_SCHED_LOOP_EN
        else if (last_acc) state_nx = PRE;
`else
        else if (last_acc) state_nx = IDLE;
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      div_l      <= '0;
      mode_l     <= '0;
      cnt        <= '0;
      bit_cnt    <= '0;
      acc        <= '0;
      gen_cnt    <= '0;
      sym_cnt    <= '0;
      pre_bit    <= 1'b0;
      sym_data   <= '0;
      sym_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      frame_done <= (state == PAY) && !stop && last_acc;
      if (!active || stop) begin
        if (!active && start && !stop) begin
          div_l  <= div;
          mode_l <= mode_eff;
        end
        cnt       <= '0;
        bit_cnt   <= '0;
        acc       <= '0;
        gen_cnt   <= '0;
        sym_cnt   <= '0;
        pre_bit   <= 1'b0;
        sym_data  <= '0;
        sym_valid <= 1'b0;
      end else begin
        if (tick || gen_done)  cnt <= '0;
        else if (cnt != div_l) cnt <= cnt + DIV_W'(1);

        if (load) begin
          sym_data  <= acc;
          sym_valid <= 1'b1;
        end else if (accept) begin
          sym_valid <= 1'b0;
        end

        if (tick) begin
          acc     <= load ? SYM_W'(in_bit) : ((acc << 1) | SYM_W'(in_bit));
          bit_cnt <= bits_after;
        end else if (load) begin
          acc     <= '0;
          bit_cnt <= '0;
        end

        if (filled) begin
          gen_cnt <= gen_cnt + CW'(1);
          pre_bit <= ~pre_bit;
        end

        if (last_acc) begin
          sym_cnt <= '0;
          gen_cnt <= '0;
          pre_bit <= 1'b0;
          cnt     <= '0;
        end else if (accept) begin
          sym_cnt <= sym_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pn_sym_sched.sv
module tb_pn_sym_sched;

  localparam int PRE_LEN   = 16;
  localparam int FRAME_LEN = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, sym_ready = 1'b1;
  logic [15:0] div = '0;
  logic [1:0]  mode = '0;
  logic        pn_bit, pn_en, sym_valid, busy, frame_done;
  logic [2:0]  sym_data;

  pn_sym_sched #(.DIV_W(16), .SYM_W(3), .PRE_LEN(PRE_LEN), .FRAME_LEN(FRAME_LEN)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .div(div), .mode(mode),
    .pn_bit(pn_bit), .pn_en(pn_en), .sym_data(sym_data), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // PN source stub: a bit array stepped by pn_en
  bit pn_arr [0:4095];
  int pn_ptr = 0;
  assign pn_bit = pn_arr[pn_ptr & 4095];
  always @(posedge clk) if (pn_en) pn_ptr++;

  task automatic fill_lfsr();
    logic [14:0] s;
    s = 15'b011101110111011;
    for (int i = 0; i < 4096; i++) begin
      pn_arr[i] = s[14];
      s = {s[13:0], s[14] ^ s[13]};
    end
  endtask

  task automatic fill_pattern(input logic [3:0] p);
    for (int i = 0; i < 4096; i++) pn_arr[i] = p[3 - (i % 4)];
  endtask

  // Frame model: the k-th accepted symbol of a frame is fully determined by
  // the preamble rule or by the PN bit stream and the symbol width.
  int m_mode = 1, m_idx = 0, pn_off = 0, pn_cnt = 0, div_cur = 0;
  int m_frames = 0, fd_seen = 0, last_pn = -1, cyc = 0;
  bit in_frame = 0, fd_pending = 0, cad_en = 0, hold_prev = 0;
  int hold_data = 0;
  int log_sym [0:PRE_LEN+FRAME_LEN-1];

  function automatic int eff(input int md);
    return (md == 0) ? 1 : ((md > 3) ? 3 : md);
  endfunction

  function automatic int exp_sym(input int k);
    int v = 0;
    if (k < PRE_LEN) return (k % 2 == 1) ? ((1 << m_mode) - 1) : 0;
    for (int i = 0; i < m_mode; i++)
      v = (v << 1) | int'(pn_arr[(pn_off + (k - PRE_LEN) * m_mode + i) & 4095]);
    return v;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      chk("frame_done", frame_done, fd_pending);
      if (frame_done) fd_seen++;
      if (!start && !stop) chk("busy", busy, in_frame);
      fd_pending = 0;
      if (hold_prev && !stop) begin
        chk("hold_valid", sym_valid, 1);
        chk("hold_data", sym_data, hold_data);
      end
      if (in_frame && sym_valid && sym_ready) begin
        chk("sym", sym_data, exp_sym(m_idx));
        log_sym[m_idx] = sym_data;
        m_idx++;
        if (m_idx == PRE_LEN + FRAME_LEN) begin
          m_frames++;
          fd_pending = 1;
`ifdef PN_SCHED_LOOP_EN
          m_idx = 0; pn_off += FRAME_LEN * m_mode; pn_cnt = 0; last_pn = -1;
`else
          in_frame = 0;
`endif
        end
      end else if (!in_frame && !stop) begin
        chk("valid_idle", sym_valid, 0);
      end
      if (pn_en) begin
        if (!in_frame || m_idx < PRE_LEN) chk("pn_en_phase", pn_en, 0);
        else begin
          pn_cnt++;
          chk("pn_bound", (pn_cnt <= m_mode * (m_idx - PRE_LEN + 2)) ? 1 : 0, 1);
          if (cad_en && last_pn >= 0) chk("pn_period", cyc - last_pn, div_cur + 1);
          last_pn = cyc;
        end
      end
      hold_prev = sym_valid && !sym_ready && in_frame && !stop;
      hold_data = sym_data;
    end
  end

  task automatic do_start(input int d, input int md);
    @(posedge clk); #1;
    div = 16'(d); mode = 2'(md); start = 1'b1;
    pn_ptr = 0; m_mode = eff(md); m_idx = 0; pn_off = 0; pn_cnt = 0;
    last_pn = -1; div_cur = d;
    @(posedge clk); #1;
    start = 1'b0; in_frame = 1;
  endtask

  task automatic do_stop();
    @(posedge clk); #1;
    stop = 1'b1; in_frame = 0;
    @(posedge clk); #1;
    stop = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_valid", sym_valid, 0);
    chk("stop_pn_en", pn_en, 0);
  endtask

  task automatic wait_idx(input int target, input string nm);
    int n = 0;
    while (m_idx < target && n < 6000) begin @(posedge clk); n++; end
    chk(nm, (m_idx >= target) ? 1 : 0, 1);
  endtask

  task automatic wait_frame();
    int f0 = m_frames;
    int n = 0;
    while (m_frames == f0 && n < 6000) begin @(posedge clk); n++; end
    chk("frame_end_seen", m_frames, f0 + 1);
`ifdef PN_SCHED_LOOP_EN
    wait_idx(2, "second_preamble");
    do_stop();
`endif
    repeat (2) @(posedge clk);
    #1 chk("idle_after_frame", busy, 0);
  endtask

  initial begin
    #1 rst = 1'b0;
    #2;
    chk("rst_pn_en", pn_en, 0);
    chk("rst_valid", sym_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_data", sym_data, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // BPSK, div=3: alternating preamble, PN15 payload, pn_en every 4 clocks
    fill_lfsr();
    cad_en = 1; sym_ready = 1'b1;
    do_start(3, 1);
    wait_frame();
    chk("t2_pre0", log_sym[0], 0);
    chk("t2_pre1", log_sym[1], 1);
    chk("t2_pre2", log_sym[2], 0);
    chk("t2_pre3", log_sym[3], 1);
    chk("t2_pay0", log_sym[16], 0);
    chk("t2_pay1", log_sym[17], 1);
    chk("t2_pay2", log_sym[18], 1);
    chk("t2_pay3", log_sym[19], 1);

    // QPSK, div=0, PN bits 1,0,1,1 repeating
    fill_pattern(4'b1011);
    do_start(0, 2);
    wait_frame();
    chk("t3_pre0", log_sym[0], 0);
    chk("t3_pre1", log_sym[1], 3);
    chk("t3_pay0", log_sym[16], 2);
    chk("t3_pay1", log_sym[17], 3);

    // 3-bit symbols with 50 clocks of backpressure mid-payload
    fill_lfsr();
    cad_en = 0;
    do_start(1, 3);
    wait_idx(PRE_LEN + 5, "t4_reach");
    #1 sym_ready = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    chk("t4_valid", sym_valid, 1);
    chk("t4_pn_count", pn_cnt, m_mode * (m_idx - PRE_LEN + 2));
    chk("t4_pre1", log_sym[1], 7);
    sym_ready = 1'b1;
    wait_frame();

    // mode 0 acts as 1 bit; stop at payload symbol 100
    do_start(0, 0);
    wait_idx(PRE_LEN + 100, "t5_reach");
    chk("t5_pre1", log_sym[1], 1);
    do_stop();
    repeat (20) @(posedge clk);
    #1 start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    chk("t5_start_stop", busy, 0);
    repeat (5) @(posedge clk);
    #1 chk("t5_still_idle", busy, 0);

    // asynchronous reset in the middle of the payload
    do_start(0, 2);
    wait_idx(PRE_LEN + 3, "t1_reach");
    @(posedge clk); #2;
    rst = 1'b0; in_frame = 0; hold_prev = 0; fd_pending = 0;
    #1;
    chk("t1_pn_en", pn_en, 0);
    chk("t1_valid", sym_valid, 0);
    chk("t1_busy", busy, 0);
    chk("t1_frame_done", frame_done, 0);
    chk("t1_data", sym_data, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk("t1_idle", busy, 0);

    chk("frame_done_count", fd_seen, m_frames);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule
